// File: rtl/par_product_pkg.sv
// Shared widths and row type for the Wallace-tree multiplier front end.
package par_product_pkg;

    localparam int OP_W   = 16;
    localparam int PROD_W = 32;
    localparam int NUM_PP = 16;

    typedef logic [PROD_W-1:0] row_t;

endpackage : par_product_pkg

// File: rtl/par_product_calc_csa.sv
// 3:2 carry-save compressor: three rows in, a sum row and a carry row out.
// The carry row is already shifted to its true weight; the bit that would
// land above W-1 is dropped, which is harmless because the product fits.
module csa_3_2
    import par_product_pkg::*;
#(
    parameter int W = PROD_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    // Bitwise full adder across the row: parity is the sum, majority the carry.
    always_comb begin
        sum   = a ^ b ^ c;
        carry = ((a & b) | (a & c) | (b & c)) << 1;
    end

endmodule : csa_3_2

// File: rtl/par_product_calc.sv
// Unsigned 16x16 multiplier front end. Partial products are reduced by a
// six-level Wallace tree of 3:2 compressors (16->11->8->6->4->3->2 rows) and
// the final sum/carry pair is registered; a downstream adder completes the
// product. There is no handshake: a new operand pair is accepted every cycle
// and its reduced vectors appear after the next rising edge.
module par_product_calc
    import par_product_pkg::*;
#(
    parameter int WIDTH = OP_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   number1,
    input  logic [WIDTH-1:0]   number0,
    output logic [2*WIDTH-1:0] add_out1,
    output logic [2*WIDTH-1:0] add_out0
);

    // Rows at each level of the tree. Within a level, compressor j writes
    // its sum to row 2j and its carry to row 2j+1; leftover rows follow.
    row_t r0 [NUM_PP];
    row_t r1 [11];
    row_t r2 [8];
    row_t r3 [6];
    row_t r4 [4];
    row_t r5 [3];
    row_t r6 [2];

    row_t sum_d, carry_d;
    row_t sum_q, carry_q;

    // Partial products: row i is number1 gated by multiplier bit i, shifted by i.
    always_comb begin
        for (int i = 0; i < NUM_PP; i++) begin
            r0[i] = number0[i] ? (PROD_W'(number1) << i) : '0;
        end
    end

    genvar j;

    // Level 1: 16 rows -> 5 compressors + 1 pass-through = 11 rows.
    generate
        for (j = 0; j < 5; j++) begin : g_l1
            csa_3_2 #(.W(PROD_W)) u_csa (
                .a(r0[3*j]), .b(r0[3*j+1]), .c(r0[3*j+2]),
                .sum(r1[2*j]), .carry(r1[2*j+1])
            );
        end
    endgenerate
    assign r1[10] = r0[15];

    // Level 2: 11 rows -> 3 compressors + 2 pass-through = 8 rows.
    generate
        for (j = 0; j < 3; j++) begin : g_l2
            csa_3_2 #(.W(PROD_W)) u_csa (
                .a(r1[3*j]), .b(r1[3*j+1]), .c(r1[3*j+2]),
                .sum(r2[2*j]), .carry(r2[2*j+1])
            );
        end
    endgenerate
    assign r2[6] = r1[9];
    assign r2[7] = r1[10];

    // Level 3: 8 rows -> 2 compressors + 2 pass-through = 6 rows.
    generate
        for (j = 0; j < 2; j++) begin : g_l3
            csa_3_2 #(.W(PROD_W)) u_csa (
                .a(r2[3*j]), .b(r2[3*j+1]), .c(r2[3*j+2]),
                .sum(r3[2*j]), .carry(r3[2*j+1])
            );
        end
    endgenerate
    assign r3[4] = r2[6];
    assign r3[5] = r2[7];

    // Level 4: 6 rows -> 2 compressors = 4 rows.
    generate
        for (j = 0; j < 2; j++) begin : g_l4
            csa_3_2 #(.W(PROD_W)) u_csa (
                .a(r3[3*j]), .b(r3[3*j+1]), .c(r3[3*j+2]),
                .sum(r4[2*j]), .carry(r4[2*j+1])
            );
        end
    endgenerate

    // Level 5: 4 rows -> 1 compressor + 1 pass-through = 3 rows.
    csa_3_2 #(.W(PROD_W)) u_csa_l5 (
        .a(r4[0]), .b(r4[1]), .c(r4[2]),
        .sum(r5[0]), .carry(r5[1])
    );
    assign r5[2] = r4[3];

    // Level 6: 3 rows -> final sum/carry pair.
    csa_3_2 #(.W(PROD_W)) u_csa_l6 (
        .a(r5[0]), .b(r5[1]), .c(r5[2]),
        .sum(r6[0]), .carry(r6[1])
    );

    // Next-state values for the output register.
    always_comb begin
        sum_d   = r6[0];
        carry_d = r6[1];
    end

    // Output register; reset clears both vectors immediately and drops any
    // operand pair that was in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            carry_q <= '0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign add_out0 = sum_q;
    assign add_out1 = carry_q;

endmodule : par_product_calc

// File: tb/tb_par_product_calc.sv
// Bench for par_product_calc: operands are driven on the falling edge, the
// expected product is queued, and the vector sum is compared just after the
// following rising edge.
module tb_par_product_calc;

    logic        clk;
    logic        rst_n;
    logic [15:0] number1;
    logic [15:0] number0;
    logic [31:0] add_out1;
    logic [31:0] add_out0;

    logic [31:0] exp_q[$];
    int          n_checks;
    int          n_errors;

    par_product_calc dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .number1 (number1),
        .number0 (number0),
        .add_out1(add_out1),
        .add_out0(add_out0)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] a32;
        logic [31:0] b32;
        a32 = {16'd0, a};
        b32 = {16'd0, b};
        return a32 * b32;
    endfunction

    // Drive one pair at the falling edge, then compare after the rising edge.
    task automatic apply(input string tag, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] exp;
        @(negedge clk);
        number1 = a;
        number0 = b;
        exp_q.push_back(ref_mul(a, b));
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'd1, 32'd0);
        end else begin
            exp = exp_q.pop_front();
            check(tag, add_out1 + add_out0, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        number1  = 16'd11451;
        number0  = 16'd250;

        // Reset held: outputs stay zero across edges.
        repeat (2) @(posedge clk);
        #1;
        check("rst_out0", add_out0, 32'd0);
        check("rst_out1", add_out1, 32'd0);

        // Release; first edge loads valid data.
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(ref_mul(16'd11451, 16'd250));
        @(posedge clk);
        #1;
        check("rst_release", add_out1 + add_out0, exp_q.pop_front());
        check("rst_release_const", add_out1 + add_out0, 32'd2862750);

        // Basic
        apply("basic_32000x11", 16'd32000, 16'd11);
        check("basic_32000x11_const", add_out1 + add_out0, 32'd352000);
        apply("basic_0x850", 16'd0, 16'd850);
        check("zero_out0", add_out0, 32'd0);
        check("zero_out1", add_out1, 32'd0);
        apply("basic_1664x2615", 16'd1664, 16'd2615);
        check("basic_1664x2615_const", add_out1 + add_out0, 32'd4351360);

        // Back-to-back, one pair per cycle
        apply("b2b_0", 16'd211, 16'd985);
        apply("b2b_1", 16'd10086, 16'd12306);
        apply("b2b_2", 16'd520, 16'd1314);
        apply("b2b_3", 16'd911, 16'd110);
        check("b2b_3_const", add_out1 + add_out0, 32'd100210);

        // Corners
        apply("max_x_max", 16'hFFFF, 16'hFFFF);
        check("max_x_max_const", add_out1 + add_out0, 32'hFFFE0001);
        apply("max_x_1", 16'hFFFF, 16'd1);
        apply("1_x_max", 16'd1, 16'hFFFF);
        apply("1_x_1", 16'd1, 16'd1);
        apply("32768_x_2", 16'd32768, 16'd2);
        check("32768_x_2_const", add_out1 + add_out0, 32'd65536);
        apply("zero_x_max", 16'hFFFF, 16'd0);
        check("zero_x_max_out0", add_out0, 32'd0);
        check("zero_x_max_out1", add_out1, 32'd0);

        // Operand change between edges: only the value at the edge counts.
        @(negedge clk);
        number1 = 16'd12345;
        number0 = 16'd54321;
        #2;
        number1 = 16'd777;
        number0 = 16'd999;
        exp_q.push_back(ref_mul(16'd777, 16'd999));
        @(posedge clk);
        #1;
        check("late_change", add_out1 + add_out0, exp_q.pop_front());

        // Mid-stream reset: pending pair is dropped, outputs clear at once.
        @(negedge clk);
        number1 = 16'd4000;
        number0 = 16'd3000;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_async_out0", add_out0, 32'd0);
        check("mid_rst_async_out1", add_out1, 32'd0);
        @(posedge clk);
        #1;
        check("mid_rst_hold_out0", add_out0, 32'd0);
        check("mid_rst_hold_out1", add_out1, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        apply("post_rst", 16'd4000, 16'd3000);

        // Random pairs, one per cycle, with occasional extreme values.
        for (int i = 0; i < 10000; i++) begin
            logic [15:0] a;
            logic [15:0] b;
            a = 16'($urandom_range(0, 65535));
            b = 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 15) == 0) a = 16'hFFFF;
            if ($urandom_range(0, 15) == 0) b = 16'($urandom_range(0, 1));
            apply("random", a, b);
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_par_product_calc
